approx_err_monitor: RTL and testbench

APPROX_ERR_MONITOR -- requirements
Module: approx_err_monitor

---
 rtl/approx_err_pkg.sv | 38 +++
 rtl/approx_err_div.sv | 97 +++++++++
 rtl/approx_err_monitor.sv | 182 ++++++++++++++++++
 tb/tb_approx_err_monitor.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_err_pkg.sv
// rtl/approx_err_pkg.sv - shared state type and width helpers for approx_err_monitor
//
// Purpose: FSM state encoding and the width functions that size the
// window counters and accumulators so that a full window of N_SAMPLES
// samples can never overflow them.
// Ports: none (package).
// Configuration: the relative-error path is enabled by defining APPROX_ERR_RE_EN.

package approx_err_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Bits needed to count 0..n_samples inclusive.
  function automatic int cnt_width(input int n_samples);
    return $clog2(n_samples + 1);
  endfunction

  // Sum of n_samples values, each at most 2w bits wide.
  function automatic int aed_sum_width(input int w, input int n_samples);
    return 2 * w + cnt_width(n_samples);
  endfunction

  // Width of one relative-error quotient (aed << frac) / exact.
  function automatic int re_quo_width(input int w, input int frac);
    return 2 * w + frac;
  endfunction

  // Sum of n_samples relative-error quotients.
  function automatic int re_sum_width(input int w, input int frac, input int n_samples);
    return re_quo_width(w, frac) + cnt_width(n_samples);
  endfunction

endpackage

// File: rtl/approx_err_div.sv
// rtl/approx_err_div.sv - sequential restoring divider for the relative-error path
//
// Purpose: computes dividend / divisor one quotient bit per cycle (QW cycles).
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           load operands and begin a division (ignored if abort)
//   abort           discard any division in progress
//   dividend [QW]   numerator
//   divisor  [NW]   denominator, must be non-zero
//   busy            division in progress
//   done            one-cycle pulse during the final iteration
//   quotient [QW]   result, valid while done is high
// Configuration: only instantiated when APPROX_ERR_RE_EN is defined.

module approx_err_div #(
  parameter int NW = 16,
  parameter int QW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [QW-1:0] dividend,
  input  logic [NW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quotient
);

  localparam int CNTW = $clog2(QW + 1);

  logic [NW-1:0]   rem_q, rem_d;
  logic [QW-1:0]   quo_q, quo_d;
  logic [NW-1:0]   dvs_q, dvs_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;

  // The remainder is always below the divisor, so the shifted partial
  // remainder fits in NW+1 bits and the difference, when taken, fits in NW.
  logic [NW:0]   shifted;
  logic          ge;
  logic [NW-1:0] step_rem;
  logic [QW-1:0] step_quo;

  assign shifted  = {rem_q, quo_q[QW-1]};
  assign ge       = (shifted >= {1'b0, dvs_q});
  assign step_rem = ge ? (shifted[NW-1:0] - dvs_q) : shifted[NW-1:0];
  assign step_quo = {quo_q[QW-2:0], ge};

  // Quotient is presented combinationally on the last iteration so the
  // caller can consume it on the same edge the divider goes idle.
  assign quotient = step_quo;
  assign busy     = busy_q;

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done   = 1'b0;
    if (abort) begin
      busy_d = 1'b0;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = CNTW'(QW);
      rem_d  = '0;
      quo_d  = dividend;
      dvs_d  = divisor;
    end else if (busy_q) begin
      rem_d = step_rem;
      quo_d = step_quo;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNTW'(1)) begin
        busy_d = 1'b0;
        done   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/approx_err_monitor.sv
// rtl/approx_err_monitor.sv - error statistics monitor for an approximate multiplier
//
// Purpose: over a window of N_SAMPLES accepted samples, accumulates the
// error count, sum and maximum of the absolute error |a*b - apprx| and,
// optionally, the sum of fixed-point relative errors.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   start            pulse: clear results and (re)arm a window
//   in_valid/in_ready sample handshake; in_ready only while collecting
//   a, b [W]         operands; apprx [2W] approximate product
//   err_count        samples with a non-zero error
//   sum_aed, max_aed sum and maximum of absolute errors
//   sum_re           sum of floor(aed * 2^RE_FRAC / exact), 0 when disabled
//   sample_cnt       samples accepted in this window
//   done             window complete, results held
// Configuration: define APPROX_ERR_RE_EN to include the divider and sum_re.

module approx_err_monitor
  import approx_err_pkg::*;
#(
  parameter int W         = 8,
  parameter int N_SAMPLES = 10000,
  parameter int RE_FRAC   = 16
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           start,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [W-1:0]                                   a,
  input  logic [W-1:0]                                   b,
  input  logic [2*W-1:0]                                 apprx,
  output logic [cnt_width(N_SAMPLES)-1:0]                err_count,
  output logic [aed_sum_width(W, N_SAMPLES)-1:0]         sum_aed,
  output logic [2*W-1:0]                                 max_aed,
  output logic [re_sum_width(W, RE_FRAC, N_SAMPLES)-1:0] sum_re,
  output logic [cnt_width(N_SAMPLES)-1:0]                sample_cnt,
  output logic                                           done
);

  localparam int CW = cnt_width(N_SAMPLES);
  localparam int SW = aed_sum_width(W, N_SAMPLES);
  localparam logic [CW-1:0] LAST = CW'(N_SAMPLES);

  state_e          state_q, state_d;
  logic            in_ready_q, done_q;
  logic [CW-1:0]   err_q, err_d;
  logic [SW-1:0]   saed_q, saed_d;
  logic [2*W-1:0]  maed_q, maed_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [2*W-1:0]  exact;
  logic [2*W-1:0]  aed;
  logic            aed_nz;
  logic            accept;
  logic            re_go;
  logic            div_busy;
  logic            div_done;

  assign exact  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign aed    = (exact >= apprx) ? (exact - apprx) : (apprx - exact);
  assign aed_nz = (aed != '0);
  // start has priority over a sample presented in the same cycle.
  assign accept = in_valid && in_ready_q && !start;

`ifdef APPROX_ERR_RE_EN
  localparam int QW = re_quo_width(W, RE_FRAC);
  localparam int RW = re_sum_width(W, RE_FRAC, N_SAMPLES);

  logic [RW-1:0] sre_q, sre_d;
  logic [QW-1:0] div_quo;

  // A zero error or zero exact product contributes nothing, so the
  // divider is bypassed and the sample completes in one cycle.
  assign re_go  = accept && aed_nz && (exact != '0);
  assign sum_re = sre_q;

  approx_err_div #(
    .NW(2 * W),
    .QW(QW)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (re_go),
    .abort   (start),
    .dividend({aed, {RE_FRAC{1'b0}}}),
    .divisor (exact),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_quo)
  );
`else
  assign re_go    = 1'b0;
  assign div_busy = 1'b0;
  assign div_done = 1'b0;
  assign sum_re   = '0;
`endif

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    saed_d  = saed_q;
    maed_d  = maed_q;
    cnt_d   = cnt_q;
`ifdef APPROX_ERR_RE_EN
    sre_d   = sre_q;
`endif
    if (start) begin
      state_d = ST_RUN;
      err_d   = '0;
      saed_d  = '0;
      maed_d  = '0;
      cnt_d   = '0;
`ifdef APPROX_ERR_RE_EN
      sre_d   = '0;
`endif
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            err_d  = err_q + CW'(aed_nz);
            saed_d = saed_q + SW'(aed);
            maed_d = (aed > maed_q) ? aed : maed_q;
            cnt_d  = cnt_q + 1'b1;
            if (re_go) begin
              state_d = ST_DIV;
            end else if (cnt_q + 1'b1 == LAST) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DIV: begin
          // sample_cnt was already advanced on the accept edge; an idle
          // divider without a done pulse means nothing is pending.
          if (div_done || !div_busy) begin
            state_d = (cnt_q == LAST) ? ST_DONE : ST_RUN;
          end
`ifdef APPROX_ERR_RE_EN
          if (div_done) begin
            sre_d = sre_q + RW'(div_quo);
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= '0;
      saed_q     <= '0;
      maed_q     <= '0;
      cnt_q      <= '0;
`ifdef APPROX_ERR_RE_EN
      sre_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == ST_RUN);
      done_q     <= (state_d == ST_DONE);
      err_q      <= err_d;
      saed_q     <= saed_d;
      maed_q     <= maed_d;
      cnt_q      <= cnt_d;
`ifdef APPROX_ERR_RE_EN
      sre_q      <= sre_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign done       = done_q;
  assign err_count  = err_q;
  assign sum_aed    = saed_q;
  assign max_aed    = maed_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_approx_err_monitor.sv
// tb/tb_approx_err_monitor.sv - scoreboard bench for approx_err_monitor

module tb_approx_err_monitor;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int RF = 16;
  localparam int CW = $clog2(N + 1);
  localparam int SW = 2 * W + CW;
  localparam int RW = 2 * W + RF + CW;
`ifdef APPROX_ERR_RE_EN
  localparam bit RE = 1'b1;
`else
  localparam bit RE = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           in_valid = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [2*W-1:0] apprx = '0;
  logic           in_ready;
  logic           done;
  logic [CW-1:0]  err_count;
  logic [CW-1:0]  sample_cnt;
  logic [SW-1:0]  sum_aed;
  logic [2*W-1:0] max_aed;
  logic [RW-1:0]  sum_re;

  always #5 clk = ~clk;

  approx_err_monitor #(.W(W), .N_SAMPLES(N), .RE_FRAC(RF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .apprx(apprx), .err_count(err_count), .sum_aed(sum_aed),
    .max_aed(max_aed), .sum_re(sum_re), .sample_cnt(sample_cnt), .done(done)
  );

  typedef struct {
    longint err;
    longint saed;
    longint maed;
    longint sre;
    longint cnt;
  } res_t;

  int   total = 0;
  int   bad = 0;
  res_t exp_q[$];
  res_t m;

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Reference: window statistics straight from the error definitions.
  task automatic model_clear();
    m = '{0, 0, 0, 0, 0};
  endtask

  task automatic model_add(input longint x, input longint y, input longint p);
    longint e;
    longint d;
    e = x * y;
    d = (e >= p) ? e - p : p - e;
    m.cnt++;
    if (d != 0) m.err++;
    m.saed += d;
    if (d > m.maed) m.maed = d;
    if (RE && d != 0 && e != 0) m.sre += (d * (64'd1 << RF)) / e;
    if (m.cnt == N) exp_q.push_back(m);
  endtask

  // Monitor: every rising done pops one expected window result.
  initial begin
    logic done_prev;
    res_t r;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        chk("sb_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          r = exp_q.pop_front();
          chk("win_err_count", err_count, r.err);
          chk("win_sum_aed", sum_aed, r.saed);
          chk("win_max_aed", max_aed, r.maed);
          chk("win_sum_re", sum_re, r.sre);
          chk("win_sample_cnt", sample_cnt, r.cnt);
          chk("win_in_ready", in_ready, 0);
        end
      end
      done_prev = done;
    end
  end

  // All tasks start and end at posedge+1.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_clear();
  endtask

  task automatic send(input int x, input int y, input int p);
    bit acc;
    a = W'(x); b = W'(y); apprx = (2*W)'(p);
    in_valid = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      if (in_ready) begin
        model_add(x, y, p);
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_sum_aed"}, sum_aed, 0);
    chk({tag, "_max_aed"}, max_aed, 0);
    chk({tag, "_sum_re"}, sum_re, 0);
    chk({tag, "_sample_cnt"}, sample_cnt, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic send_random();
    int x, y, e, p;
    x = $urandom_range(0, 255);
    y = $urandom_range(0, 255);
    e = x * y;
    case ($urandom_range(0, 3))
      0: p = e;
      1: p = e + $urandom_range(0, 6) - 3;
      2: p = $urandom_range(0, 65535);
      default: begin x = 0; e = 0; p = $urandom_range(0, 300); end
    endcase
    if (p < 0) p = 0;
    if (p > 65535) p = 65535;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    send(x, y, p);
  endtask

  initial begin
    int low;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    chk("reset_in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Error-free window, then check results hold in DONE.
    pulse_start();
    chk("ready_after_start", in_ready, 1);
    repeat (4) send(15, 15, 225);
    wait_done();
    in_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    chk("held_sample_cnt", sample_cnt, N);
    chk("held_in_ready", in_ready, 0);
    chk("held_done", done, 1);

    // Mixed window including exact==0 and error-free samples.
    pulse_start();
    send(255, 255, 65000);
    send(10, 10, 110);
    send(0, 7, 3);
    send(2, 2, 4);
    wait_done();
    chk("mix_err_count", err_count, 3);
    chk("mix_sum_aed", sum_aed, 38);
    chk("mix_max_aed", max_aed, 25);
    chk("mix_sum_re", sum_re, RE ? (25 * 65536) / 65025 + 6553 : 0);

    // Divider stall length and relative-error value.
    pulse_start();
    send(10, 10, 110);
    low = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) break;
      low++;
    end
    @(posedge clk); #1;
    chk("div_stall_cycles", low, RE ? 32 : 0);
    repeat (3) send(12, 12, 144);
    wait_done();
    chk("re_10x10", sum_re, RE ? 6553 : 0);

    // Abort right after a sample that starts a division.
    pulse_start();
    send(3, 3, 9);
    send(10, 10, 110);
    pulse_start();
    check_zero("abort");
    chk("abort_in_ready", in_ready, 1);
    repeat (4) send_random();
    wait_done();

    // start and in_valid in the same cycle: the sample is dropped.
    pulse_start();
    send(1, 1, 1);
    a = 8'd9; b = 8'd9; apprx = 16'd1;
    in_valid = 1'b1;
    pulse_start();
    in_valid = 1'b0;
    check_zero("start_vs_valid");
    repeat (4) send_random();
    wait_done();

    // Reset for one edge in RUN with a sample offered.
    pulse_start();
    send(4, 4, 17);
    a = 8'd5; b = 8'd5; apprx = 16'd30;
    in_valid = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    check_zero("mid_reset");
    chk("mid_reset_in_ready", in_ready, 0);
    pulse_start();
    chk("start_after_reset", in_ready, 1);
    repeat (4) send_random();
    wait_done();

    // Random windows.
    for (int w = 0; w < 25; w++) begin
      pulse_start();
      repeat (N) send_random();
      wait_done();
    end

    @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
